multicycle_control: RTL
=======================

Name: multicycle_control

Overview:
- Main control FSM of the multicycle CPU. Sits directly downstream of the instruction register and consumes its opcode field, Instruction[31:26].
- Drives every datapath control line, including IRWrite back into the instruction register.
- Supports six instructions: R-type (000000), lw (100011), sw (101011), beq (000100), addi (001000) and j (000010). Memory accesses stall on a MemReady handshake.

Parameters:
- STATE_WIDTH, 4, width of the State register and State port.
- OP_WIDTH, 6, opcode width; fixed at 6 for this ISA.

Ports:
- clock  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous, active-low reset.
- Op  input  OP_WIDTH  opcode, from Instruction[31:26] of the instruction register.
- MemReady  input  1  memory has completed the current access; tie high for single-cycle memory.
- PCWrite  output  1  unconditional PC load.
- PCWriteCond  output  1  PC load qualified by ALU Zero.
- IorD  output  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  output  1  memory read enable.
- MemWrite  output  1  memory write enable.
- MemtoReg  output  1  register write-data select: 1 = MDR.
- IRWrite  output  1  instruction register capture enable.
- PCSource  output  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- ALUOp  output  2  ALU op class: 00 = add, 01 = sub, 10 = funct.
- ALUSrcA  output  1  ALU A select: 0 = PC, 1 = A register.
- ALUSrcB  output  2  ALU B select: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2.
- RegWrite  output  1  register file write enable.
- RegDst  output  1  destination register select: 1 = rd, 0 = rt.
- IllegalOp  output  1  one-cycle flag for an unsupported opcode.
- State  output  STATE_WIDTH  current state, for debug.

Behaviour:
- Interface (already decided): one clock, `clock`; reset `reset_n` is asynchronous and active-low.
- reset_n low: State goes to FETCH immediately and IllegalOp clears to 0. Reset mid-instruction abandons that instruction; no further writes are issued.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXECUTE=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEXEC=10, ADDIWB=11. Codes 12-15 go to FETCH on the next posedge.
- Outputs are decoded combinationally from State. Exception: in FETCH, PCWrite and IRWrite equal MemReady. Every output not listed below is 0.
- Reset values: FETCH outputs. MemRead=1, ALUSrcB=01, IRWrite=PCWrite=MemReady, all else 0.
- Per-state outputs and transitions:
  - FETCH: outputs above. Stays while MemReady=0; goes to DECODE when MemReady=1. The IR captures on the negedge and presents the instruction at the posedge ending FETCH, so Op is valid throughout DECODE.
  - DECODE: ALUSrcB=11. Samples Op:
    - lw or sw -> MEMADR
    - R-type -> EXECUTE
    - beq -> BRANCH
    - j -> JUMP
    - addi -> ADDIEXEC
    - anything else -> FETCH
  - MEMADR: ALUSrcA=1, ALUSrcB=10. lw -> MEMRD, sw -> MEMWR. Op is re-sampled here; the IR is stable.
  - MEMRD: MemRead=1, IorD=1. Holds until MemReady=1, then -> MEMWB.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0. -> FETCH.
  - MEMWR: MemWrite=1, IorD=1. Holds until MemReady=1, then -> FETCH.
  - EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> ALUWB.
  - ALUWB: RegWrite=1, RegDst=1. -> FETCH.
  - BRANCH: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01. -> FETCH.
  - JUMP: PCWrite=1, PCSource=10. -> FETCH.
  - ADDIEXEC: ALUSrcA=1, ALUSrcB=10. -> ADDIWB.
  - ADDIWB: RegWrite=1. -> FETCH.
- IllegalOp is registered. It is 1 for exactly the one cycle following a DECODE that saw an unsupported Op, and 0 otherwise.
- Latency with MemReady held high, in cycles:
  - lw 5
  - sw 4
  - R-type 4
  - addi 4
  - beq 3
  - j 3
- Each MemReady=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- MemRead and MemWrite are never both 1. RegWrite and any PC write are never both 1.

Test Plan:
- Reset: reset_n=0 mid-MEMRD -> State=0 with no clock edge. MemRead=1, ALUSrcB=01, IllegalOp=0. Release reset and hold MemReady=1 -> PCWrite=IRWrite=1 in the first cycle.
- lw (Op=100011) with MemReady=1 -> State sequence 0,1,2,3,4,0. RegWrite=1 and MemtoReg=1 only in state 4.
- sw (Op=101011) with MemReady held low for 3 cycles in MEMWR -> State 5 for 4 cycles with MemWrite=1 throughout, then 0.
- R-type (000000) then beq (000100) then j (000010) back to back -> states 0,1,6,7, then 0,1,8, then 0,1,9. PCSource is 01 in state 8 and 10 in state 9.
- Fetch stall: MemReady low for 2 cycles in FETCH -> State stays 0 and PCWrite=IRWrite=0. Both go to 1 in the MemReady=1 cycle, then -> DECODE.
- Op=111111 in DECODE -> next State=0 and IllegalOp=1 for one cycle, then 0. No RegWrite, MemWrite or PCWriteCond asserted in between.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle CPU: decodes the IR opcode into a
// per-state sequence of datapath control lines, stalling on MemReady.
module multicycle_control #(
  parameter int STATE_WIDTH = 4,
  parameter int OP_WIDTH    = 6
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [OP_WIDTH-1:0]    Op,
  input  logic                   MemReady,
  output logic                   PCWrite,
  output logic                   PCWriteCond,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   MemtoReg,
  output logic                   IRWrite,
  output logic [1:0]             PCSource,
  output logic [1:0]             ALUOp,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic                   RegWrite,
  output logic                   RegDst,
  output logic                   IllegalOp,
  output logic [STATE_WIDTH-1:0] State
);

  localparam logic [OP_WIDTH-1:0] OP_RTYPE = OP_WIDTH'(6'b000000);
  localparam logic [OP_WIDTH-1:0] OP_LW    = OP_WIDTH'(6'b100011);
  localparam logic [OP_WIDTH-1:0] OP_SW    = OP_WIDTH'(6'b101011);
  localparam logic [OP_WIDTH-1:0] OP_BEQ   = OP_WIDTH'(6'b000100);
  localparam logic [OP_WIDTH-1:0] OP_ADDI  = OP_WIDTH'(6'b001000);
  localparam logic [OP_WIDTH-1:0] OP_J     = OP_WIDTH'(6'b000010);

  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH    = STATE_WIDTH'(0),
    DECODE   = STATE_WIDTH'(1),
    MEMADR   = STATE_WIDTH'(2),
    MEMRD    = STATE_WIDTH'(3),
    MEMWB    = STATE_WIDTH'(4),
    MEMWR    = STATE_WIDTH'(5),
    EXECUTE  = STATE_WIDTH'(6),
    ALUWB    = STATE_WIDTH'(7),
    BRANCH   = STATE_WIDTH'(8),
    JUMP     = STATE_WIDTH'(9),
    ADDIEXEC = STATE_WIDTH'(10),
    ADDIWB   = STATE_WIDTH'(11)
  } state_t;

  state_t state, next;
  logic   op_legal;

  assign op_legal = (Op == OP_RTYPE) || (Op == OP_LW) || (Op == OP_SW) ||
                    (Op == OP_BEQ)   || (Op == OP_ADDI) || (Op == OP_J);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH;
      IllegalOp <= 1'b0;
    end else begin
      state     <= next;
      IllegalOp <= (state == DECODE) && !op_legal;
    end
  end

  assign State = state;

  // Unused codes 12-15 fall through to the default and recover to FETCH.
  always_comb begin
    next = FETCH;
    case (state)
      FETCH:    next = MemReady ? DECODE : FETCH;
      DECODE: begin
        if (Op == OP_LW || Op == OP_SW) next = MEMADR;
        else if (Op == OP_RTYPE)        next = EXECUTE;
        else if (Op == OP_BEQ)          next = BRANCH;
        else if (Op == OP_J)            next = JUMP;
        else if (Op == OP_ADDI)         next = ADDIEXEC;
        else                            next = FETCH;
      end
      MEMADR: begin
        if (Op == OP_LW)      next = MEMRD;
        else if (Op == OP_SW) next = MEMWR;
        else                  next = FETCH;
      end
      MEMRD:    next = MemReady ? MEMWB : MEMRD;
      MEMWB:    next = FETCH;
      MEMWR:    next = MemReady ? FETCH : MEMWR;
      EXECUTE:  next = ALUWB;
      ALUWB:    next = FETCH;
      BRANCH:   next = FETCH;
      JUMP:     next = FETCH;
      ADDIEXEC: next = ADDIWB;
      ADDIWB:   next = FETCH;
      default:  next = FETCH;
    endcase
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    case (state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC+4 and IR capture only commit once the fetch read completes.
        IRWrite = MemReady;
        PCWrite = MemReady;
      end
      DECODE:   ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      EXECUTE: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      JUMP: begin
        PCWrite  = 1'b1;
        PCSource = 2'b10;
      end
      ADDIEXEC: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB:   RegWrite = 1'b1;
      default: ;
    endcase
  end

endmodule
